// File: rtl/dt_pkg.sv
// Shared types and table-entry layout for the decision-tree walker.
// Field offsets are derived from the design parameters.
package dt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_DONE
    } dt_state_t;

    localparam logic [1:0] CMP_LE = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    function automatic int fidx_w(input int nf);
        return (nf > 1) ? $clog2(nf) : 1;
    endfunction

    function automatic int entry_w(input int fw, input int nf,
                                   input int aw, input int cw);
        return 1 + fidx_w(nf) + fw + 2 * aw + cw;
    endfunction

    function automatic int cls_lsb();
        return 0;
    endfunction

    function automatic int right_lsb(input int cw);
        return cw;
    endfunction

    function automatic int left_lsb(input int aw, input int cw);
        return cw + aw;
    endfunction

    function automatic int thr_lsb(input int aw, input int cw);
        return cw + 2 * aw;
    endfunction

    function automatic int fidx_lsb(input int fw, input int aw,
                                    input int cw);
        return thr_lsb(aw, cw) + fw;
    endfunction

    function automatic int leaf_bit(input int fw, input int nf,
                                    input int aw, input int cw);
        return fidx_lsb(fw, aw, cw) + fidx_w(nf);
    endfunction

endpackage

// File: rtl/dt_node.sv
// Registered threshold comparator for one tree node.
// result: 1 = feature <= train, 2 = feature > train.
module node #(
    parameter int FEATURE_WIDE = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FEATURE_WIDE-1:0] feature,
    input  logic [FEATURE_WIDE-1:0] train,
    output logic [1:0]              result
);
    import dt_pkg::*;

    // Register the unsigned compare; ties go left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 2'd0;
        end else begin
            result <= (feature <= train) ? CMP_LE : CMP_GT;
        end
    end

endmodule

// File: rtl/dt_tree_walker.sv
// Decision-tree inference controller walking a programmable node table.
// Define DT_DEPTH_GUARD_EN to abort walks that visit too many nodes.
module dt_tree_walker
    import dt_pkg::*;
#(
    parameter int FEATURE_WIDE = 7,
    parameter int N_FEATURES   = 4,
    parameter int N_NODES      = 15,
    parameter int NODE_AW      = 4,
    parameter int CLASS_W      = 2,
    parameter int FIDX_W       = fidx_w(N_FEATURES),
    parameter int ENTRY_W      = entry_w(FEATURE_WIDE, N_FEATURES,
                                         NODE_AW, CLASS_W)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_FEATURES*FEATURE_WIDE-1:0] features,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CLASS_W-1:0]                 out_class,
    output logic                               out_err,
    input  logic                               cfg_we,
    input  logic [NODE_AW-1:0]                 cfg_addr,
    input  logic [ENTRY_W-1:0]                 cfg_wdata
);
    localparam int CLS_L  = cls_lsb();
    localparam int RGT_L  = right_lsb(CLASS_W);
    localparam int LFT_L  = left_lsb(NODE_AW, CLASS_W);
    localparam int THR_L  = thr_lsb(NODE_AW, CLASS_W);
    localparam int FIDX_L = fidx_lsb(FEATURE_WIDE, NODE_AW, CLASS_W);
    localparam int LEAF_B = leaf_bit(FEATURE_WIDE, N_FEATURES,
                                     NODE_AW, CLASS_W);

    localparam logic [ENTRY_W-1:0] LEAF0 = {1'b1, {(ENTRY_W-1){1'b0}}};

    dt_state_t state_q, state_d;

    logic [ENTRY_W-1:0]                 table_q [N_NODES];
    logic [NODE_AW-1:0]                 ptr_q;
    logic [N_FEATURES*FEATURE_WIDE-1:0] feat_q;
    logic [CLASS_W-1:0]                 class_q;
    logic                               err_q;

    logic [ENTRY_W-1:0]      entry;
    logic                    e_leaf;
    logic [FIDX_W-1:0]       e_fidx;
    logic [FEATURE_WIDE-1:0] e_thr;
    logic [NODE_AW-1:0]      e_left;
    logic [NODE_AW-1:0]      e_right;
    logic [CLASS_W-1:0]      e_class;

    logic [FEATURE_WIDE-1:0] cmp_feat;
    logic [1:0]              cmp_res;
    logic [NODE_AW-1:0]      child;
    logic                    res_ok;
    logic                    child_ok;
    logic                    guard_hit;

    logic ld_sample, ld_leaf, ld_err, ld_child;

    assign entry   = table_q[ptr_q];
    assign e_leaf  = entry[LEAF_B];
    assign e_fidx  = entry[FIDX_L +: FIDX_W];
    assign e_thr   = entry[THR_L +: FEATURE_WIDE];
    assign e_left  = entry[LFT_L +: NODE_AW];
    assign e_right = entry[RGT_L +: NODE_AW];
    assign e_class = entry[CLS_L +: CLASS_W];

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_class = class_q;
    assign out_err   = err_q;

    // Select the feature named by the current node; out-of-range picks 0.
    always_comb begin
        cmp_feat = feat_q[0 +: FEATURE_WIDE];
        for (int i = 1; i < N_FEATURES; i++) begin
            if (int'(e_fidx) == i) begin
                cmp_feat = feat_q[i*FEATURE_WIDE +: FEATURE_WIDE];
            end
        end
    end

    node #(
        .FEATURE_WIDE(FEATURE_WIDE)
    ) u_node (
        .clk    (clk),
        .rst_n  (rst_n),
        .feature(cmp_feat),
        .train  (e_thr),
        .result (cmp_res)
    );

    assign res_ok   = (cmp_res == CMP_LE) || (cmp_res == CMP_GT);
    assign child    = (cmp_res == CMP_LE) ? e_left : e_right;
    assign child_ok = (int'(child) < N_NODES);

`ifdef DT_DEPTH_GUARD_EN
    logic [NODE_AW:0] step_q;

    assign guard_hit = (int'(step_q) == N_NODES - 1);

    // Count node fetches so a cyclic table cannot walk forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else if (ld_sample) begin
            step_q <= '0;
        end else if (state_q == S_FETCH) begin
            step_q <= step_q + 1'b1;
        end
    end
`else
    assign guard_hit = 1'b0;
`endif

    // Walk control: next state and datapath load strobes.
    always_comb begin
        state_d   = state_q;
        ld_sample = 1'b0;
        ld_leaf   = 1'b0;
        ld_err    = 1'b0;
        ld_child  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ld_sample = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (e_leaf) begin
                    ld_leaf = 1'b1;
                    state_d = S_DONE;
                end else if (guard_hit) begin
                    ld_err  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!res_ok || !child_ok) begin
                    ld_err  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ld_child = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample latch, node pointer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            feat_q  <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (ld_sample) begin
                ptr_q  <= '0;
                feat_q <= features;
            end else if (ld_child) begin
                ptr_q <= child;
            end
            if (ld_leaf) begin
                class_q <= e_class;
                err_q   <= 1'b0;
            end else if (ld_err) begin
                class_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Node table: writable only while idle, resets to all leaf class 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) begin
                table_q[i] <= LEAF0;
            end
        end else if (cfg_we && state_q == S_IDLE &&
                     int'(cfg_addr) < N_NODES) begin
            table_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: tb/tb_dt_tree_walker.sv
// Randomized self-checking bench for dt_tree_walker.
// Expected results come from a plain table-walk model.
module tb_dt_tree_walker;

    localparam int FW = 7;
    localparam int NF = 4;
    localparam int NN = 15;
    localparam int AW = 4;
    localparam int CW = 2;
    localparam int EW = 1 + 2 + FW + 2 * AW + CW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NF*FW-1:0] features;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_class;
    logic          out_err;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [EW-1:0] cfg_wdata;

    int n_checks;
    int n_fail;

    int m_leaf [NN];
    int m_feat [NN];
    int m_thr  [NN];
    int m_l    [NN];
    int m_r    [NN];
    int m_cls  [NN];

    dt_tree_walker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .features (features),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_err  (out_err),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] pack(input int leaf, input int f,
                                           input int thr, input int l,
                                           input int r, input int c);
        logic [0:0]    b_leaf;
        logic [1:0]    b_f;
        logic [FW-1:0] b_thr;
        logic [AW-1:0] b_l;
        logic [AW-1:0] b_r;
        logic [CW-1:0] b_c;
        b_leaf = 1'(leaf);
        b_f    = 2'(f);
        b_thr  = FW'(thr);
        b_l    = AW'(l);
        b_r    = AW'(r);
        b_c    = CW'(c);
        return {b_leaf, b_f, b_thr, b_l, b_r, b_c};
    endfunction

    task automatic model_reset_table();
        for (int i = 0; i < NN; i++) begin
            m_leaf[i] = 1;
            m_feat[i] = 0;
            m_thr[i]  = 0;
            m_l[i]    = 0;
            m_r[i]    = 0;
            m_cls[i]  = 0;
        end
    endtask

    task automatic model_set(input int i, input int leaf, input int f,
                             input int thr, input int l, input int r,
                             input int c);
        m_leaf[i] = leaf;
        m_feat[i] = f;
        m_thr[i]  = thr;
        m_l[i]    = l;
        m_r[i]    = r;
        m_cls[i]  = c;
    endtask

    // Program one entry (DUT must be idle) and mirror it in the model.
    task automatic prog(input int i, input int leaf, input int f,
                        input int thr, input int l, input int r,
                        input int c);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(i);
        cfg_wdata = pack(leaf, f, thr, l, r, c);
        tick();
        cfg_we = 1'b0;
        model_set(i, leaf, f, thr, l, r, c);
    endtask

    // Reference walk: class, error flag and edges from accept to DONE.
    task automatic model_walk(input logic [NF*FW-1:0] fv,
                              output int cls, output int err,
                              output int lat);
        int p;
        int fetches;
        int k;
        int fi;
        int x;
        int nxt;
        p = 0;
        fetches = 0;
        k = 0;
        cls = 0;
        err = 1;
        lat = -1;
        while (fetches < 1000) begin
            fetches++;
            if (m_leaf[p] != 0) begin
                cls = m_cls[p];
                err = 0;
                lat = 2 * k + 1;
                return;
            end
`ifdef DT_DEPTH_GUARD_EN
            if (fetches >= NN) begin
                cls = 0;
                err = 1;
                lat = 2 * k + 1;
                return;
            end
`endif
            fi  = (m_feat[p] < NF) ? m_feat[p] : 0;
            x   = int'(fv[fi*FW +: FW]);
            nxt = (x <= m_thr[p]) ? m_l[p] : m_r[p];
            k++;
            if (nxt >= NN) begin
                cls = 0;
                err = 1;
                lat = 2 * k;
                return;
            end
            p = nxt;
        end
    endtask

    // Wait for the result, check it, optionally stall, then handshake.
    task automatic finish_sample(input int cls, input int err,
                                 input int lat, input int hold);
        int cyc;
        logic [CW-1:0] c0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            if (out_valid) break;
            tick();
            cyc = i;
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("done_timeout", 32'(out_valid), 32'd1);
            return;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("class", 32'(out_class), 32'(cls));
        check("err", 32'(out_err), 32'(err));
        c0 = out_class;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_class", 32'(out_class), 32'(c0));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic run_sample(input logic [NF*FW-1:0] fv, input int hold);
        int cls;
        int err;
        int lat;
        model_walk(fv, cls, err, lat);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        features = fv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        features = '0;
        finish_sample(cls, err, lat, hold);
    endtask

    function automatic logic [NF*FW-1:0] f1_only(input int v);
        logic [NF*FW-1:0] fv;
        fv = '0;
        fv[1*FW +: FW] = FW'(v);
        return fv;
    endfunction

    function automatic logic [NF*FW-1:0] rand_feats();
        logic [NF*FW-1:0] fv;
        for (int i = 0; i < NF; i++) begin
            fv[i*FW +: FW] = FW'($urandom_range(0, (1 << FW) - 1));
        end
        return fv;
    endfunction

    // Random acyclic table; children point forward, sometimes past the end.
    task automatic rand_table();
        int l;
        int r;
        for (int i = 0; i < NN; i++) begin
            if (i >= NN - 2 || $urandom_range(0, 2) == 0) begin
                prog(i, 1, 0, 0, 0, 0, $urandom_range(0, 3));
            end else begin
                l = $urandom_range(i + 1, NN - 1);
                r = $urandom_range(i + 1, NN - 1);
                if ($urandom_range(0, 9) == 0) l = NN;
                if ($urandom_range(0, 9) == 0) r = NN;
                prog(i, 0, $urandom_range(0, NF - 1),
                     $urandom_range(0, (1 << FW) - 1), l, r, 0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset_table();
        tick();
    endtask

    task automatic directed_table();
        prog(0, 0, 1, 20, 1, 2, 0);
        prog(1, 1, 0, 0, 0, 0, 1);
        prog(2, 1, 0, 0, 0, 0, 2);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        features  = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        model_reset_table();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // All-leaf table after reset: class 0 one edge after accept.
        run_sample(rand_feats(), 0);
        finish_sample_noop();

        // Directed threshold tie and just-above cases with stall.
        directed_table();
        run_sample(f1_only(20), 10);
        run_sample(f1_only(21), 0);
        run_sample(f1_only(0), 0);
        run_sample(f1_only(127), 0);

        // Child index past the table end aborts at EVAL.
        prog(0, 0, 1, 20, NN, 2, 0);
        run_sample(f1_only(5), 0);
        run_sample(f1_only(50), 0);

        // Write during EVAL is dropped; walk still reaches class 1.
        directed_table();
        check("eval_in_ready", 32'(in_ready), 32'd1);
        features = f1_only(20);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        cfg_we    = 1'b1;
        cfg_addr  = 4'd1;
        cfg_wdata = pack(1, 0, 0, 0, 0, 3);
        tick();
        cfg_we = 1'b0;
        finish_sample(1, 0, 3 - 2, 0);
        run_sample(f1_only(20), 0);

        // Write coinciding with accept is performed and seen by the walk.
        model_set(0, 1, 0, 0, 0, 0, 3);
        features  = f1_only(20);
        in_valid  = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = pack(1, 0, 0, 0, 0, 3);
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        finish_sample(3, 0, 1, 0);

        // Out-of-range address write is dropped.
        cfg_we    = 1'b1;
        cfg_addr  = 4'd15;
        cfg_wdata = pack(1, 0, 0, 0, 0, 2);
        tick();
        cfg_we = 1'b0;
        run_sample(rand_feats(), 0);

`ifdef DT_DEPTH_GUARD_EN
        // Self-looping root trips the depth guard.
        prog(0, 0, 0, 64, 0, 0, 0);
        run_sample(rand_feats(), 0);
        run_sample(rand_feats(), 0);
`endif

        // Randomized tables and samples against the model.
        for (int t = 0; t < 6; t++) begin
            rand_table();
            for (int s = 0; s < 8; s++) begin
                run_sample(rand_feats(), $urandom_range(0, 2));
            end
        end

        // Reset mid-walk discards the walk and restores the table.
        directed_table();
        prog(1, 0, 2, 10, 3, 4, 0);
        features = rand_feats();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_class", 32'(out_class), 32'd0);
        tick();
        rst_n = 1'b1;
        model_reset_table();
        tick();
        run_sample(f1_only(3), 0);
        run_sample(f1_only(99), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    task automatic finish_sample_noop();
        tick();
    endtask

endmodule
